// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param; the FIFO attaches through the slave modport.
interface sync_fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [AW:0]      level;
   logic             overflow;
   logic             underflow;
   logic             clr_err;
   logic [AW:0]      hwm;

   modport master (
      output wr_en, wr_data, rd_en, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow, hwm
   );

   modport slave (
      input  wr_en, wr_data, rd_en, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow, hwm
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, threshold flags and sticky access errors.
// Optional high-water mark register enabled by defining SYNC_FIFO_HWM_EN.
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   sync_fifo_param_if.slave fifo_io
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] ZERO_LV  = (AW+1)'(0);
   localparam logic [AW:0] ONE_LV   = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_LV = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_LV    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_LV    = (AW+1)'(AE_THRESH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             empty_s, full_s, rd_acc_s, wr_acc_s;

   // Flags come from the level register only, so they never see input paths.
   always_comb begin
      empty_s  = (level_q == ZERO_LV);
      full_s   = (level_q == DEPTH_LV);
      rd_acc_s = fifo_io.rd_en & ~empty_s;
      wr_acc_s = fifo_io.wr_en & (~full_s | rd_acc_s);
   end

   // Next-state for pointers, level, read port and sticky errors.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_acc_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_acc_s) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = 1'b1;
      end else begin
         rd_ptr_d   = rd_ptr_q;
         rd_valid_d = 1'b0;
      end

      case ({wr_acc_s, rd_acc_s})
         2'b10:   level_d = level_q + ONE_LV;
         2'b01:   level_d = level_q - ONE_LV;
         default: level_d = level_q;
      endcase

      // A fresh rejection in the same cycle as clr_err keeps the bit set.
      if (fifo_io.wr_en & ~wr_acc_s) begin
         overflow_d = 1'b1;
      end else if (fifo_io.clr_err) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end

      if (fifo_io.rd_en & ~rd_acc_s) begin
         underflow_d = 1'b1;
      end else if (fifo_io.clr_err) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // Control and read-port state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         level_q     <= ZERO_LV;
         rd_data_q   <= {WIDTH{1'b0}};
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_q[wr_ptr_q] <= fifo_io.wr_data;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

`ifdef SYNC_FIFO_HWM_EN
   logic [AW:0] hwm_q, hwm_d;

   // Peak tracking uses the post-update level; clr_err restarts from it.
   always_comb begin
      hwm_d = hwm_q;
      if (fifo_io.clr_err) begin
         hwm_d = level_d;
      end else if (level_d > hwm_q) begin
         hwm_d = level_d;
      end else begin
         hwm_d = hwm_q;
      end
   end

   // High-water mark register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_q <= ZERO_LV;
      end else begin
         hwm_q <= hwm_d;
      end
   end

   assign fifo_io.hwm = hwm_q;
`else
   assign fifo_io.hwm = ZERO_LV;
`endif

   assign fifo_io.rd_data      = rd_data_q;
   assign fifo_io.rd_valid     = rd_valid_q;
   assign fifo_io.full         = full_s;
   assign fifo_io.empty        = empty_s;
   assign fifo_io.almost_full  = (level_q >= AF_LV);
   assign fifo_io.almost_empty = (level_q <= AE_LV);
   assign fifo_io.level        = level_q;
   assign fifo_io.overflow     = overflow_q;
   assign fifo_io.underflow    = underflow_q;
endmodule
